// File: rtl/prog_loader.sv
// Program loader and run supervisor for the 9-bit CPU: streams host words into
// imem with the CPU held in reset, then runs it until done or timeout.
module prog_loader #(
  parameter int unsigned IW   = 9,
  parameter int unsigned AW   = 9,
  parameter int unsigned MAXW = 512,
  parameter logic [15:0] TMO  = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          s_valid,
  input  logic [IW-1:0] s_data,
  output logic          s_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic          busy,
  output logic          run_done,
  output logic          err,
  output logic [15:0]   cycles
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   count_q, count_d;
  logic            s_ready_q, s_ready_d;
  logic            im_we_q, im_we_d;
  logic [AW-1:0]   im_addr_q, im_addr_d;
  logic [IW-1:0]   im_wdata_q, im_wdata_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            busy_q, busy_d;
  logic            run_done_q, run_done_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cycles_q, cycles_d;

  logic            len_ok;
  logic            accept;
  logic            last_word;

  assign len_ok    = (len != '0) && (len <= LW'(MAXW));
  assign accept    = s_valid && s_ready_q;
  assign last_word = (count_q == (len_q - LW'(1)));

  // Next-state, datapath and registered output decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    run_done_d = run_done_q;
    err_d      = err_q;
    cycles_d   = cycles_q;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          if (len_ok) begin
            len_d      = len;
            count_d    = '0;
            run_done_d = 1'b0;
            err_d      = 1'b0;
            cycles_d   = '0;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          im_we_d    = 1'b1;
          im_addr_d  = count_q[AW-1:0];
          im_wdata_d = s_data;
          count_d    = count_q + LW'(1);
          if (last_word) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // done takes priority over a coincident timeout
        if (cpu_done) begin
          run_done_d = 1'b1;
          err_d      = 1'b0;
          state_d    = S_HALT;
        end else if (cycles_q == TMO) begin
          run_done_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_HALT;
        end else begin
          cycles_d = cycles_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d   = (state_d == S_LOAD);
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = (state_d == S_LOAD) || (state_d == S_DRAIN) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      s_ready_q   <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
      err_q       <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      run_done_q  <= run_done_d;
      err_q       <= err_d;
      cycles_q    <= cycles_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign run_done  = run_done_q;
  assign err       = err_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized directed bench for prog_loader with a behavioural load/run model
// and a shadow imem built from the observed write port.
module tb_prog_loader;

  localparam int unsigned IW   = 9;
  localparam int unsigned AW   = 9;
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned MAXW = 512;
  localparam logic [15:0] TMO  = 16'd20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic          s_valid;
  logic [IW-1:0] s_data;
  logic          s_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          cpu_reset;
  logic          cpu_done;
  logic          busy;
  logic          run_done;
  logic          err;
  logic [15:0]   cycles;

  int n_assert = 0;
  int n_fail   = 0;
  int last_rd  = 0;
  int last_cyc = 0;

  logic [IW-1:0] mem  [MAXW];
  logic [IW-1:0] prog [MAXW];

  prog_loader #(
    .IW  (IW),
    .AW  (AW),
    .MAXW(MAXW),
    .TMO (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_reset(cpu_reset),
    .cpu_done (cpu_done),
    .busy     (busy),
    .run_done (run_done),
    .err      (err),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_we) mem[im_addr] <= im_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a load of L words and streams them; ends at the first RUN cycle.
  task automatic do_load(input int L, input int gap_pct, input bit keep,
                         input logic [31:0] pat, input int pat_len);
    int acc;
    bit fired;
    if (!keep) for (int i = 0; i < L; i++) prog[i] = IW'($urandom);
    start = 1'b1;
    len   = LW'(L);
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", s_ready, 1);
    chk("load_err", err, 0);
    chk("load_rdone", run_done, 0);
    chk("load_cycles", cycles, 0);
    chk("load_cpurst", cpu_reset, 1);
    acc = 0;
    for (int t = 0; t < 8 * L + 64 && acc < L; t++) begin
      if (pat_len > 0) s_valid = (t < pat_len) ? pat[t] : 1'b1;
      else             s_valid = ($urandom_range(99) >= gap_pct);
      s_data   = s_valid ? prog[acc] : IW'($urandom);
      cpu_done = 1'($urandom);
      start    = ($urandom_range(7) == 0);
      len      = LW'($urandom);
      fired    = s_valid;
      @(negedge clk);
      chk("load_we", im_we, fired);
      if (fired) begin
        chk("load_addr", im_addr, acc);
        chk("load_wdata", im_wdata, prog[acc]);
        acc++;
      end
      if (acc < L) chk("load_ready_hold", s_ready, 1);
    end
    chk("load_completed", acc, L);
    s_valid  = 1'b0;
    start    = 1'b0;
    cpu_done = 1'($urandom);
    chk("drain_ready", s_ready, 0);
    chk("drain_busy", busy, 1);
    chk("drain_cpurst", cpu_reset, 1);
    chk("drain_err", err, 0);
    @(negedge clk);
    chk("run_cpurst", cpu_reset, 0);
    chk("run_we", im_we, 0);
    chk("run_cycles0", cycles, 0);
    for (int i = 0; i < L; i++) chk("imem", mem[i], prog[i]);
  endtask

  // Runs the CPU; done_at<0 means cpu_done never rises.
  task automatic do_run(input int done_at);
    int exp_c;
    bit ended;
    exp_c = 0;
    ended = 1'b0;
    for (int t = 0; t < int'(TMO) + 5 && !ended; t++) begin
      chk("run_cpurst_hold", cpu_reset, 0);
      chk("run_busy", busy, 1);
      chk("run_cycles", cycles, exp_c);
      cpu_done = (done_at >= 0) && (exp_c == done_at);
      start    = ($urandom_range(3) == 0);
      len      = LW'($urandom_range(1, MAXW));
      @(negedge clk);
      if (cpu_done) begin
        ended = 1'b1;
        chk("done_rdone", run_done, 1);
        chk("done_err", err, 0);
        chk("done_cycles", cycles, exp_c);
        last_rd = 1;
      end else if (exp_c == int'(TMO)) begin
        ended = 1'b1;
        chk("tmo_rdone", run_done, 0);
        chk("tmo_err", err, 1);
        chk("tmo_cycles", cycles, int'(TMO));
        last_rd = 0;
      end else begin
        exp_c++;
      end
    end
    start    = 1'b0;
    last_cyc = exp_c;
    chk("run_ended", ended, 1);
    chk("halt_cpurst", cpu_reset, 1);
    chk("halt_busy", busy, 0);
    chk("halt_ready", s_ready, 0);
    for (int i = 0; i < 2; i++) begin
      cpu_done = 1'($urandom);
      @(negedge clk);
      chk("halt_rdone_hold", run_done, last_rd);
      chk("halt_cycles_hold", cycles, last_cyc);
      chk("halt_busy_hold", busy, 0);
    end
  endtask

  // Start with an out-of-range length: only err changes.
  task automatic bad_start(input int L, input int exp_rd, input int exp_cyc);
    start = 1'b1;
    len   = LW'(L);
    @(negedge clk);
    start = 1'b0;
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_ready", s_ready, 0);
    chk("bad_cpurst", cpu_reset, 1);
    chk("bad_rdone", run_done, exp_rd);
    chk("bad_cycles", cycles, exp_cyc);
    @(negedge clk);
    chk("bad_stay", busy, 0);
  endtask

  initial begin
    int L;
    int da;
    reset    = 1'b0;
    start    = 1'b0;
    len      = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    cpu_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpurst", cpu_reset, 1);
    chk("rst_ready", s_ready, 0);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdone", run_done, 0);
    chk("rst_err", err, 0);
    chk("rst_cycles", cycles, 0);
    reset = 1'b1;
    @(negedge clk);

    // Async reset in the middle of a load
    start = 1'b1;
    len   = LW'(8);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = IW'($urandom);
      @(negedge clk);
    end
    chk("midload_we", im_we, 1);
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    chk("arst_cpurst", cpu_reset, 1);
    chk("arst_ready", s_ready, 0);
    chk("arst_we", im_we, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cpurst", cpu_reset, 1);

    // Bad lengths in IDLE, then minimum length with timeout
    bad_start(0, 0, 0);
    bad_start(int'(MAXW) + 1, 0, 0);
    do_load(1, 0, 1'b0, 32'h0, 0);
    do_run(-1);

    // Basic load with no gaps, then run for 10 cycles
    prog[0] = 9'h0C1;
    prog[1] = 9'h0C2;
    prog[2] = 9'h0C3;
    prog[3] = 9'h1FF;
    do_load(4, 0, 1'b1, 32'h0, 0);
    do_run(10);

    // Gapped stream 1,0,0,1,0,1
    do_load(3, 0, 1'b0, 32'b101001, 6);
    do_run($urandom_range(0, 19));

    // Bad length in HALT keeps run_done and cycles
    bad_start(0, last_rd, last_cyc);

    // done coinciding with timeout
    do_load($urandom_range(1, 16), 30, 1'b0, 32'h0, 0);
    do_run(int'(TMO));

    // Full-size program, no address wrap
    do_load(int'(MAXW), 25, 1'b0, 32'h0, 0);
    do_run(0);

    // Random loads and runs
    for (int k = 0; k < 5; k++) begin
      L  = $urandom_range(1, 40);
      da = $urandom_range(0, 25);
      do_load(L, $urandom_range(0, 60), 1'b0, 32'h0, 0);
      do_run((da > int'(TMO)) ? -1 : da);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side counterpart of the 9-bit CPU top. The CPU only reads instruction memory and raises `done`; this block is the writer and run supervisor for it.
- Streams a program from a host valid/ready interface into the imem write port while holding the CPU in reset.
- Then releases the CPU, counts execution cycles, and parks the CPU again when `done` (or a timeout) is seen.

Parameters:
- IW, 9, instruction word width (matches inst[8:0]).
- AW, 9, imem address width (matches PC[8:0]).
- MAXW, 512, maximum program length in words (2**AW).
- TMO, 16'hFFFF, run-cycle limit before forced halt.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  input  1  single-cycle request to begin a load; sampled in IDLE and HALT only.
- len  input  AW+1  program length in words; valid range 1..MAXW; sampled with start.
- s_valid  input  1  host word valid.
- s_data  input  IW  host instruction word.
- s_ready  output  1  block accepts a word this cycle.
- im_we  output  1  imem write enable (registered).
- im_addr  output  AW  imem write address (registered).
- im_wdata  output  IW  imem write data (registered).
- cpu_reset  output  1  active-high reset to CPU top.
- cpu_done  input  1  CPU `done` flag (inst==9'h1FF).
- busy  output  1  state is LOAD, DRAIN or RUN.
- run_done  output  1  last run ended by cpu_done.
- err  output  1  bad len at start, or run timeout.
- cycles  output  16  RUN cycles elapsed before done.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cpu_reset=1.
  - s_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - busy=0, run_done=0, err=0, cycles=0, internal word count=0.
  - Reset mid-load or mid-run abandons the operation; partial imem contents are left as written.
- States: IDLE, LOAD, DRAIN, RUN, HALT. cpu_reset=1 in every state except RUN.
- IDLE/HALT, start=1:
  - If 1<=len<=MAXW: latch len, count=0, clear run_done/err/cycles, go to LOAD.
  - Otherwise: err=1, state unchanged, other flags unchanged.
  - start=0: hold state.
- LOAD:
  - s_ready=1 (Moore, state decode only).
  - Handshake is s_valid&s_ready. Accept in cycle k gives im_we=1, im_addr=count, im_wdata=s_data in cycle k+1; then count+1.
  - im_we=0 in cycles with no accept. s_valid gaps are allowed and hold the count.
  - The accept of word len-1 moves the state to DRAIN, so s_ready=0 in the next cycle.
- DRAIN (one cycle): the final im_we is visible. Next state is RUN.
- RUN:
  - cpu_reset=0 from the first RUN cycle.
  - Each cycle with cpu_done=0: cycles+1.
  - cpu_done=1: go to HALT, set run_done=1, freeze cycles (no increment that cycle).
  - cycles==TMO with cpu_done=0: go to HALT, err=1, run_done=0.
  - If cpu_done and timeout coincide, done wins: run_done=1, err=0.
  - cpu_done is ignored outside RUN.
- HALT: cpu_reset=1; flags and cycles hold until the next valid start.
- start in LOAD/DRAIN/RUN is ignored.
- The address counter never wraps: len=512 writes addresses 0..511 exactly.
- im_addr/im_wdata hold their last value when im_we=0.

Test Plan:
- Reset value check: assert reset=0 mid-LOAD after 3 words → immediately cpu_reset=1, s_ready=0, im_we=0, busy=0; after release, state=IDLE.
- Basic load: start, len=4, words 9'h0C1,9'h0C2,9'h0C3,9'h1FF with no gaps →
  - im_we pulses at addr 0..3 with matching data, each one cycle after its accept.
  - s_ready low after the 4th accept.
  - cpu_reset drops 2 cycles after the 4th accept.
- Gapped stream: len=3, s_valid toggles 1,0,0,1,0,1 → exactly 3 writes at addr 0,1,2; no write in gap cycles.
- Run/done: after load, hold cpu_done=0 for 10 RUN cycles, then 1 → cycles=10, run_done=1, cpu_reset=1, busy=0.
- Bad length: start with len=0, then len=513 → err=1, state IDLE, s_ready=0. Then start with len=1 → err clears, LOAD entered.
- Timeout: bench built with TMO=16'd20, cpu_done held 0 → HALT at cycles=20, err=1, run_done=0. Then rerun with cpu_done=1 exactly when cycles=20 → run_done=1, err=0.
